// File: rtl/cla_pkg.sv
// Shared types and helpers for the sequential carry-lookahead adder controller.
// Contents: controller state enum, nibble width, index-width helper.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned nib);
        return (nib < 2) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder, purely combinational.
// Ports: i_a, i_b (4-bit operands), i_cin (carry-in),
//        o_sum_c (4-bit sum), o_cout_c (carry-out).
module cla_4bit
    import cla_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum_c,
    output logic                o_cout_c
);

    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Flattened lookahead carries, no ripple between bit positions.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum_c  = w_p ^ w_c[NIBBLE_W-1:0];
    assign o_cout_c = w_c[NIBBLE_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-precision add/subtract controller: one shared 4-bit CLA processes a
// WIDTH-bit operation one nibble per cycle, LSB nibble first.
// Ports: clk, rst_n (async active-low); input handshake in_valid/in_ready with
//        a, b, sub, cin; output handshake out_valid/out_ready with sum, cout, ovf.
// Optional macro CLA_EARLY_DONE_EN: finish as soon as carry and all remaining
// operand nibbles are zero (data-dependent latency 1..NIB).
module cla_seq_adder_ctrl
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W = idx_w(NIB);
    localparam int unsigned SH_W  = IDX_W + 2;

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, r_b, r_acc, r_sum;
    logic [WIDTH-1:0]   w_a_nxt, w_b_nxt, w_acc_nxt, w_sum_nxt, w_acc_ins;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_carry, r_a_msb, r_b_msb, r_cout, r_ovf, r_out_valid, r_in_ready;
    logic               w_carry_nxt, w_a_msb_nxt, w_b_msb_nxt, w_cout_nxt, w_ovf_nxt;
    logic               w_out_valid_nxt, w_in_ready_nxt;
    logic [SH_W-1:0]    w_shamt;
    logic [NIBBLE_W-1:0] w_a_nib, w_b_nib, w_cla_sum;
    logic               w_cla_cout, w_accept, w_last;

    assign w_accept = in_valid & r_in_ready;
    assign w_last   = (r_idx == IDX_W'(NIB - 1));
    assign w_shamt  = {r_idx, 2'b00};
    assign w_a_nib  = NIBBLE_W'(r_a >> w_shamt);
    assign w_b_nib  = NIBBLE_W'(r_b >> w_shamt);

    cla_4bit u_cla (
        .i_a      (w_a_nib),
        .i_b      (w_b_nib),
        .i_cin    (r_carry),
        .o_sum_c  (w_cla_sum),
        .o_cout_c (w_cla_cout)
    );

    // Accumulator with the current nibble replaced by the CLA result.
    always_comb begin
        w_acc_ins = r_acc;
        for (int i = 0; i < NIB; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_acc_ins[i*NIBBLE_W +: NIBBLE_W] = w_cla_sum;
            end
        end
    end

`ifdef CLA_EARLY_DONE_EN
    logic             w_early;
    logic [WIDTH-1:0] w_keep;
    // Nothing left to add: carry clear and every operand bit from idx upward is zero.
    assign w_early = ~r_carry && ((r_a >> w_shamt) == '0) && ((r_b >> w_shamt) == '0);
    assign w_keep  = ~({WIDTH{1'b1}} << w_shamt);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = RUN;
            RUN: begin
                if (w_last) w_state_nxt = DONE;
`ifdef CLA_EARLY_DONE_EN
                if (w_early) w_state_nxt = DONE;
`endif
            end
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values; everything lands in registers below.
    always_comb begin
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_sum_nxt   = r_sum;
        w_idx_nxt   = r_idx;
        w_carry_nxt = r_carry;
        w_a_msb_nxt = r_a_msb;
        w_b_msb_nxt = r_b_msb;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_a_nxt     = a;
                    w_b_nxt     = sub ? ~b : b;
                    w_carry_nxt = sub ? 1'b1 : cin;
                    w_a_msb_nxt = a[WIDTH-1];
                    w_b_msb_nxt = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    w_idx_nxt   = '0;
                    w_acc_nxt   = '0;
                end
            end
            RUN: begin
                w_acc_nxt   = w_acc_ins;
                w_carry_nxt = w_cla_cout;
                w_idx_nxt   = r_idx + IDX_W'(1);
                if (w_last) begin
                    w_sum_nxt  = w_acc_ins;
                    w_cout_nxt = w_cla_cout;
                    w_ovf_nxt  = (r_a_msb == r_b_msb) && (w_acc_ins[WIDTH-1] != r_a_msb);
                end
`ifdef CLA_EARLY_DONE_EN
                if (w_early) begin
                    w_acc_nxt   = r_acc & w_keep;
                    w_sum_nxt   = r_acc & w_keep;
                    w_carry_nxt = 1'b0;
                    w_cout_nxt  = 1'b0;
                    w_ovf_nxt   = (r_a_msb == r_b_msb) && (w_acc_nxt[WIDTH-1] != r_a_msb);
                end
`endif
            end
            default: ;
        endcase
        w_out_valid_nxt = (w_state_nxt == DONE);
        w_in_ready_nxt  = (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_acc       <= w_acc_nxt;
            r_sum       <= w_sum_nxt;
            r_idx       <= w_idx_nxt;
            r_carry     <= w_carry_nxt;
            r_a_msb     <= w_a_msb_nxt;
            r_b_msb     <= w_b_msb_nxt;
            r_cout      <= w_cout_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed testbench for cla_seq_adder_ctrl (WIDTH=16).
module tb_cla_seq_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    int n_total = 0;
    int n_bad   = 0;
    int lat;

    cla_seq_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and return edges from accept to out_valid (left pending).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_in,
                          input logic tsub, input logic tcin, output int tlat);
        int n;
        a = ta; b = tb_in; sub = tsub; cin = tcin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs: must be ignored while busy.
        a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1; cin = 1'b1;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        tlat = 0;
        while (!out_valid && tlat < 20) begin
            @(posedge clk); #1; tlat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ov_drop", 32'(out_valid), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
    endtask

    logic [15:0] held_sum;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add with fixed latency.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        chk("add1_lat", 32'(lat), 32'd4);
        chk("add1_sum", 32'(sum), 32'h5555);
        chk("add1_cout", 32'(cout), 32'd0);
        chk("add1_ovf", 32'(ovf), 32'd0);
        release_out();

        // Carry ripples through every nibble.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("ripple_lat", 32'(lat), 32'd4);
        chk("ripple_sum", 32'(sum), 32'h0000);
        chk("ripple_cout", 32'(cout), 32'd1);
        chk("ripple_ovf", 32'(ovf), 32'd0);
        release_out();
        chk("keep_sum", 32'(sum), 32'h0000);
        chk("keep_cout", 32'(cout), 32'd1);

        // Signed overflow.
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("ovf_sum", 32'(sum), 32'h8000);
        chk("ovf_ovf", 32'(ovf), 32'd1);
        chk("ovf_cout", 32'(cout), 32'd0);
        release_out();

        // Subtract with borrow; cin ignored.
        run_op(16'h0003, 16'h0005, 1'b1, 1'b1, lat);
        chk("sub_lat", 32'(lat), 32'd4);
        chk("sub_sum", 32'(sum), 32'hFFFE);
        chk("sub_cout", 32'(cout), 32'd0);
        chk("sub_ovf", 32'(ovf), 32'd0);
        release_out();

        // Add with carry-in.
        run_op(16'h00FF, 16'h0F00, 1'b0, 1'b1, lat);
        chk("cin_sum", 32'(sum), 32'h1000);
        chk("cin_cout", 32'(cout), 32'd0);

        // Backpressure: result held stable for five cycles.
        held_sum = sum;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_ov", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(sum), 32'(held_sum));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        // Present the next request right as the result is released.
        a = 16'h0010; b = 16'h0020; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rel_ov", 32'(out_valid), 32'd0);
        chk("rel_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next_accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("next_sum", 32'(sum), 32'h0030);
        release_out();

        // Reset in the middle of RUN (idx=2) with a live carry.
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_sum", 32'(sum), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        chk("postrst_sum", 32'(sum), 32'h0002);
        chk("postrst_cout", 32'(cout), 32'd0);
        release_out();

        // Small operands: latency depends on early termination build option.
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        chk("small_sum", 32'(sum), 32'h0007);
`ifdef CLA_EARLY_DONE_EN
        chk("small_lat", 32'(lat), 32'd2);
`else
        chk("small_lat", 32'(lat), 32'd4);
`endif
        release_out();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
- Multi-precision add/subtract controller that time-shares one 4-bit carry-lookahead adder across all nibbles of a WIDTH-bit operation.
- Processes one nibble per cycle, least-significant nibble first, with a registered carry between nibbles.
- Used wherever a wide adder is too costly and multi-cycle latency is acceptable.
- Uses valid/ready handshakes on the input and output sides.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8 (elaboration error otherwise).
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  controller can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  1 = compute A-B, 0 = compute A+B+cin
- cin  in  1  carry-in; ignored when sub=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, nibble index=0, carry register=0.
- Reset mid-operation abandons the operation immediately; no partial result is ever presented.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register a, and register b (stored as ~b when sub=1).
  - Carry register loads cin when sub=0, or 1 when sub=1.
  - Register the operand MSBs (for overflow), clear index, go to RUN.
- FSM RUN:
  - in_ready=0.
  - Each cycle, feed nibble[idx] of A and B plus the carry register to the 4-bit CLA.
  - Write the CLA sum into sum[4*idx+3:4*idx]. Carry register takes the CLA carry-out. idx increments.
  - On the cycle idx==NIB-1, go to DONE.
- FSM DONE:
  - out_valid=1. cout = final carry register. ovf = (A_msb==B'_msb) && (sum_msb!=A_msb), where B' is the stored (possibly inverted) B.
  - sum, cout and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE; out_valid deasserts on the next cycle. sum, cout and ovf keep their last values until the next result overwrites them.
- Latency: out_valid rises exactly NIB clock edges after the accepting edge.
- Throughput: one operation per NIB+2 cycles minimum. There is no input/output overlap; in_ready is 0 in both RUN and DONE.
- Width and wrap: sum is modulo 2^WIDTH. Carry out of the top nibble goes only to cout.
- Input changes while not in IDLE are ignored.
- in_valid with out_ready held high is legal; back-to-back operations are separated by exactly one IDLE cycle.

Optional Feature:
- Macro: CLA_EARLY_DONE_EN.
- Defined: in RUN, if the carry register is 0 and all stored A and B' bits at and above nibble idx are zero, then:
  - remaining sum nibbles are cleared;
  - cout=0;
  - ovf is computed as normal;
  - the FSM goes to DONE next cycle.
  - Latency becomes data-dependent, from 1 to NIB edges.
  - Subtraction with nonzero upper bits of ~b never terminates early.
- Undefined: fixed latency of NIB; no early-termination logic is synthesised.

Decomposition:
- Shared package cla_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - NIBBLE_W=4;
  - a function returning the index width, clog2(NIB).
- One sub-module: the team's existing 4-bit carry-lookahead adder cla_4bit, instantiated once as the shared datapath.
- All sequencing, operand registers and the carry register live in cla_seq_adder_ctrl.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h4321, sub=0, cin=0 -> sum=16'h5555, cout=0, ovf=0; out_valid exactly 4 edges after accept.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0 (carry ripples through all 4 nibbles).
- a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1, cout=0. Then a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0, ovf=0.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and ovf stable and in_ready=0. Assert out_ready -> IDLE next cycle; a new in_valid is accepted one cycle later.
- Pulse rst_n low during RUN at idx=2 -> out_valid=0 and in_ready=1 immediately. The next operation 16'h0001+16'h0001 gives 16'h0002, with no corruption from the old carry.
- With CLA_EARLY_DONE_EN defined: a=16'h0003, b=16'h0004, sub=0 -> sum=16'h0007 with out_valid 2 edges after accept. Without the macro, the same operation takes 4 edges.
